// File: rtl/sub_bytes_iter.sv
// Iterative forward AES SubBytes: substitutes a 128-bit state LANES bytes per cycle
// through a shared bank of S-boxes, with valid/ready handshakes on both sides.
module sub_bytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NGRP = 16 / LANES;
    localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * 32'(x) -: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [127:0]    work;
    logic [127:0]    work_nxt;
    int unsigned     grp_base;

    assign out_data = work;
    assign grp_base = 32'(cnt) * LANES;

    // Only LANES lookups exist; the group counter steers them to the current bytes.
    always_comb begin
        work_nxt = work;
        for (int unsigned l = 0; l < LANES; l++) begin
            work_nxt[8 * (15 - (grp_base + l)) +: 8] = sbox(work[8 * (15 - (grp_base + l)) +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(NGRP - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one instance per legal LANES value, checked against a
// GF(2^8) inverse + affine S-box model built at time zero.
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [5];
    logic         in_ready  [5];
    logic [127:0] in_data   [5];
    logic         out_valid [5];
    logic         out_ready [5];
    logic [127:0] out_data  [5];
    logic         busy      [5];

    int nvec = 0;
    int nerr = 0;
    logic [7:0] sbox_ref [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_ref(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8 * i +: 8] = sbox_ref[x[8 * i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s (LANES=%0d): observed %h expected %h", tag, 1 << k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k);
        chk({tag, "_in_ready"}, k, 128'(in_ready[k]), 128'd1);
        chk({tag, "_out_valid"}, k, 128'(out_valid[k]), 128'd0);
        chk({tag, "_busy"}, k, 128'(busy[k]), 128'd0);
    endtask

    // Present one block; returns at the negedge following the accepting edge.
    task automatic accept(input int k, input logic [127:0] d);
        int n = 0;
        while (in_ready[k] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", k, 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        @(negedge clk);
        in_valid[k] = $urandom_range(0, 1) == 1;
        in_data[k]  = rnd128();
    endtask

    // Follows BUSY to DONE, checking latency, flags and the substituted state.
    task automatic wait_done(input int k, input logic [127:0] exp, input bit rnd_ready);
        int n = 0;
        while (out_valid[k] !== 1'b1 && n < 40) begin
            chk("busy_in_ready", k, 128'(in_ready[k]), 128'd0);
            chk("busy_flag", k, 128'(busy[k]), 128'd1);
            if (rnd_ready) out_ready[k] = $urandom_range(0, 1) == 1;
            @(negedge clk);
            n++;
        end
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        chk("latency", k, 128'(n), 128'(16 >> k));
        chk("out_data", k, out_data[k], exp);
        chk("done_in_ready", k, 128'(in_ready[k]), 128'd0);
        chk("done_busy", k, 128'(busy[k]), 128'd1);
    endtask

    task automatic release_out(input int k, input int nstall);
        logic [127:0] held = out_data[k];
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            chk("stall_data", k, out_data[k], held);
            chk("stall_valid", k, 128'(out_valid[k]), 128'd1);
        end
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk_idle("release", k);
    endtask

    initial begin
        logic [127:0] blk_a;
        logic [127:0] blk_b;
        logic [127:0] d;

        build_sbox();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk_idle("reset", k);
            chk("reset_data", k, out_data[k], 128'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 round 1 SubBytes, byte order and all-zero states.
        accept(2, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        wait_done(2, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
        release_out(2, 0);
        accept(0, 128'h0);
        wait_done(0, {16{8'h63}}, 1'b0);
        release_out(0, 1);
        accept(4, 128'h0);
        wait_done(4, {16{8'h63}}, 1'b0);
        release_out(4, 0);
        accept(2, 128'h000102030405060708090a0b0c0d0e0f);
        wait_done(2, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
        release_out(2, 0);

        // Hold DONE with a second block waiting upstream.
        blk_a = rnd128();
        blk_b = rnd128();
        accept(2, blk_a);
        wait_done(2, sub_ref(blk_a), 1'b0);
        in_valid[2] = 1'b1;
        in_data[2]  = blk_b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", 2, out_data[2], sub_ref(blk_a));
            chk("bp_in_ready", 2, 128'(in_ready[2]), 128'd0);
            chk("bp_out_valid", 2, 128'(out_valid[2]), 128'd1);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        chk_idle("bp_release", 2);
        @(negedge clk);
        in_valid[2] = 1'b0;
        wait_done(2, sub_ref(blk_b), 1'b0);
        release_out(2, 0);

        // Reset during the second BUSY cycle aborts the block.
        accept(2, rnd128());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort", 2);
        chk("abort_data", 2, out_data[2], 128'h0);
        accept(2, {16{8'hff}});
        wait_done(2, {16{8'h16}}, 1'b0);
        release_out(2, 0);

        // Random states with random out_ready activity and stalls.
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 1000; n++) begin
                d = rnd128();
                accept(k, d);
                wait_done(k, sub_ref(d), 1'b1);
                release_out(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
